// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, stall, flush and an optional
// skid entry. Control payload is zeroed whenever no valid entry is presented.
module pipe_stage_reg #(
    parameter int DATA_W = 96,
    parameter int CTRL_W = 8,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        count
);

    localparam bit LP_SKID = (SKID != 0);

    // r_alive keeps in_ready low until the first edge after reset release
    logic              r_alive;
    logic              r_m_valid;
    logic [DATA_W-1:0] r_m_data;
    logic [CTRL_W-1:0] r_m_ctrl;
    logic              r_s_valid;
    logic [DATA_W-1:0] r_s_data;
    logic [CTRL_W-1:0] r_s_ctrl;
    logic [1:0]        r_count;

    logic              w_in_fire;
    logic              w_out_fire;
    logic              w_m_valid_nxt;
    logic [DATA_W-1:0] w_m_data_nxt;
    logic [CTRL_W-1:0] w_m_ctrl_nxt;
    logic              w_s_valid_nxt;
    logic [DATA_W-1:0] w_s_data_nxt;
    logic [CTRL_W-1:0] w_s_ctrl_nxt;
    logic [1:0]        w_count_nxt;

    generate
        if (LP_SKID) begin : g_skid_ready
            assign in_ready = r_alive & ~r_s_valid & ~flush;
        end else begin : g_comb_ready
            assign in_ready = r_alive & ~flush & (~r_m_valid | out_ready);
        end
    endgenerate

    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = r_m_valid & out_ready;

    always_comb begin
        w_m_valid_nxt = r_m_valid;
        w_m_data_nxt  = r_m_data;
        w_m_ctrl_nxt  = r_m_ctrl;
        w_s_valid_nxt = r_s_valid;
        w_s_data_nxt  = r_s_data;
        w_s_ctrl_nxt  = r_s_ctrl;

        if (flush) begin
            // Bubble insertion: data is left in place, only side-effecting controls are cleared
            w_m_valid_nxt = 1'b0;
            w_s_valid_nxt = 1'b0;
            w_m_ctrl_nxt  = '0;
            w_s_ctrl_nxt  = '0;
        end else if (w_out_fire && r_s_valid) begin
            w_m_data_nxt  = r_s_data;
            w_m_ctrl_nxt  = r_s_ctrl;
            w_s_valid_nxt = 1'b0;
            w_s_ctrl_nxt  = '0;
        end else if (w_in_fire && (!r_m_valid || w_out_fire)) begin
            w_m_valid_nxt = 1'b1;
            w_m_data_nxt  = in_data;
            w_m_ctrl_nxt  = in_ctrl;
        end else if (w_in_fire && LP_SKID) begin
            w_s_valid_nxt = 1'b1;
            w_s_data_nxt  = in_data;
            w_s_ctrl_nxt  = in_ctrl;
        end else if (w_out_fire) begin
            w_m_valid_nxt = 1'b0;
            w_m_ctrl_nxt  = '0;
        end
    end

    assign w_count_nxt = 2'(w_m_valid_nxt) + 2'(w_s_valid_nxt);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_alive   <= 1'b0;
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_ctrl  <= '0;
            r_s_valid <= 1'b0;
            r_s_data  <= '0;
            r_s_ctrl  <= '0;
            r_count   <= 2'd0;
        end else begin
            r_alive   <= 1'b1;
            r_m_valid <= w_m_valid_nxt;
            r_m_data  <= w_m_data_nxt;
            r_m_ctrl  <= w_m_ctrl_nxt;
            r_s_valid <= w_s_valid_nxt;
            r_s_data  <= w_s_data_nxt;
            r_s_ctrl  <= w_s_ctrl_nxt;
            r_count   <= w_count_nxt;
        end
    end

    assign out_valid = r_m_valid;
    assign out_data  = r_m_data;
    assign out_ctrl  = r_m_ctrl & {CTRL_W{r_m_valid}};
    assign count     = r_count;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: drives a SKID=1 and a SKID=0 instance from shared inputs and
// compares both against queue-based models of the stage.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [95:0] in_data;
    logic [7:0]  in_ctrl;
    logic        out_ready;

    logic        a_in_ready, a_out_valid, b_in_ready, b_out_valid;
    logic [95:0] a_out_data, b_out_data;
    logic [7:0]  a_out_ctrl, b_out_ctrl;
    logic [1:0]  a_count, b_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(96), .CTRL_W(8), .SKID(1)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_data(a_out_data), .out_ctrl(a_out_ctrl), .count(a_count)
    );

    pipe_stage_reg #(.DATA_W(96), .CTRL_W(8), .SKID(0)) dut0 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_data(b_out_data), .out_ctrl(b_out_ctrl), .count(b_count)
    );

    typedef struct packed {
        logic [95:0] d;
        logic [7:0]  c;
    } ent_t;

    // Models: qa is a FIFO of capacity 2 (skid), qb capacity 1; last_* is the held data
    ent_t        qa[$];
    ent_t        qb[$];
    logic [95:0] last_a = '0;
    logic [95:0] last_b = '0;
    bit          alive  = 1'b0;

    function automatic bit ready_a();
        return alive && !flush && (qa.size() < 2);
    endfunction

    function automatic bit ready_b();
        return alive && !flush && (qb.size() == 0 || out_ready);
    endfunction

    task automatic model_step();
        bit   ra, rb, ofa, ofb;
        ent_t e;
        ent_t junk;
        if (!rst) begin
            qa.delete();
            qb.delete();
            last_a = '0;
            last_b = '0;
            alive  = 1'b0;
        end else begin
            ra  = ready_a();
            rb  = ready_b();
            ofa = (qa.size() > 0) && out_ready;
            ofb = (qb.size() > 0) && out_ready;
            e.d = in_data;
            e.c = in_ctrl;
            if (flush) begin
                qa.delete();
                qb.delete();
            end else begin
                if (ofa) junk = qa.pop_front();
                if (in_valid && ra) qa.push_back(e);
                if (ofb) junk = qb.pop_front();
                if (in_valid && rb) qb.push_back(e);
            end
            if (qa.size() > 0) last_a = qa[0].d;
            if (qb.size() > 0) last_b = qb[0].d;
            alive = 1'b1;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        in_data = {$urandom, $urandom, $urandom}; in_ctrl = 8'hA5;
        tick();
        tick();
        #3;
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", a_out_valid); end
        checks++; if (a_out_ctrl !== 8'h00) begin errors++; $display("FAIL reset_ctrl: got %h expected 00", a_out_ctrl); end
        checks++; if (a_count !== 2'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", a_count); end
        checks++; if (a_out_data !== 96'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", a_out_data); end
        checks++; if (b_out_valid !== 1'b0 || b_count !== 2'd0) begin errors++; $display("FAIL reset_skid0: got valid=%b count=%0d expected 0/0", b_out_valid, b_count); end
        @(posedge clk); #1;
        rst = 1'b1;
        in_valid = 1'b0;
        tick();
        in_valid = 1'b1; in_data = 96'h1234; in_ctrl = 8'h81;
        #3;
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", a_in_ready); end
        tick();
        in_valid = 1'b0;
        #3;
        checks++; if (a_out_valid !== 1'b1 || a_out_data !== 96'h1234 || a_out_ctrl !== 8'h81)
            begin errors++; $display("FAIL first_xfer: got %b/%h/%h expected 1/1234/81", a_out_valid, a_out_data, a_out_ctrl); end
        checks++; if (b_out_valid !== 1'b1 || b_out_data !== 96'h1234 || b_out_ctrl !== 8'h81)
            begin errors++; $display("FAIL first_xfer_skid0: got %b/%h/%h expected 1/1234/81", b_out_valid, b_out_data, b_out_ctrl); end
        drain();
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_data = 96'(i); in_ctrl = 8'(i + 8'h10);
            #3;
            checks++; if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready[%0d]: got %b/%b expected 1/1", i, a_in_ready, b_in_ready); end
            if (i > 0) begin
                checks++; if (a_out_valid !== 1'b1 || a_out_data !== 96'(i - 1) || a_out_ctrl !== 8'(i - 1 + 8'h10))
                    begin errors++; $display("FAIL stream_out[%0d]: got %b/%h/%h expected 1/%h/%h", i, a_out_valid, a_out_data, a_out_ctrl, i - 1, i - 1 + 8'h10); end
                checks++; if (b_out_data !== 96'(i - 1)) begin errors++; $display("FAIL stream_out_skid0[%0d]: got %h expected %h", i, b_out_data, i - 1); end
            end
            tick();
        end
        in_valid = 1'b0;
        #3;
        checks++; if (a_out_valid !== 1'b1 || a_out_data !== 96'd7) begin errors++; $display("FAIL stream_last: got %b/%h expected 1/7", a_out_valid, a_out_data); end
        drain();
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 96'hA; in_ctrl = 8'h0A;
        tick();
        in_data = 96'hB; in_ctrl = 8'h0B;
        #3;
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL stall_skid_ready: got %b expected 1", a_in_ready); end
        tick();
        in_valid = 1'b0;
        #3;
        checks++; if (a_count !== 2'd2 || a_in_ready !== 1'b0 || a_out_data !== 96'hA || a_out_ctrl !== 8'h0A)
            begin errors++; $display("FAIL stall_full: got count=%0d rdy=%b out=%h/%h expected 2/0/A/0A", a_count, a_in_ready, a_out_data, a_out_ctrl); end
        tick();
        out_ready = 1'b1;
        #3;
        checks++; if (a_out_data !== 96'hA || a_count !== 2'd2) begin errors++; $display("FAIL stall_hold: got %h/%0d expected A/2", a_out_data, a_count); end
        tick();
        #3;
        checks++; if (a_out_valid !== 1'b1 || a_out_data !== 96'hB || a_out_ctrl !== 8'h0B || a_count !== 2'd1)
            begin errors++; $display("FAIL stall_second: got %b/%h/%h/%0d expected 1/B/0B/1", a_out_valid, a_out_data, a_out_ctrl, a_count); end
        tick();
        #3;
        checks++; if (a_out_valid !== 1'b0 || a_count !== 2'd0) begin errors++; $display("FAIL stall_empty: got %b/%0d expected 0/0", a_out_valid, a_count); end
        drain();
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 96'hC; in_ctrl = 8'hCC;
        tick();
        in_data = 96'hD; in_ctrl = 8'hDD;
        tick();
        flush = 1'b1; in_data = 96'hE; in_ctrl = 8'hEE;
        #3;
        checks++; if (a_in_ready !== 1'b0 || b_in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b/%b expected 0/0", a_in_ready, b_in_ready); end
        tick();
        flush = 1'b0; in_valid = 1'b0;
        #3;
        checks++; if (a_out_valid !== 1'b0 || a_out_ctrl !== 8'h00 || a_count !== 2'd0 || a_out_data !== 96'hC)
            begin errors++; $display("FAIL flush_a: got %b/%h/%0d/%h expected 0/00/0/C", a_out_valid, a_out_ctrl, a_count, a_out_data); end
        checks++; if (b_out_valid !== 1'b0 || b_out_ctrl !== 8'h00 || b_count !== 2'd0)
            begin errors++; $display("FAIL flush_b: got %b/%h/%0d expected 0/00/0", b_out_valid, b_out_ctrl, b_count); end
        out_ready = 1'b1;
        tick();
        #3;
        checks++; if (a_out_valid !== 1'b0 || b_out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_capture: got %b/%b expected 0/0", a_out_valid, b_out_valid); end
        drain();
    endtask

    task automatic test_bubble();
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 96'hF00D; in_ctrl = 8'hFF;
        tick();
        in_valid = 1'b0;
        #3;
        checks++; if (a_out_valid !== 1'b1 || a_out_ctrl !== 8'hFF) begin errors++; $display("FAIL bubble_entry: got %b/%h expected 1/FF", a_out_valid, a_out_ctrl); end
        tick();
        #3;
        checks++; if (a_out_valid !== 1'b0 || a_out_ctrl !== 8'h00 || a_out_data !== 96'hF00D)
            begin errors++; $display("FAIL bubble_a: got %b/%h/%h expected 0/00/F00D", a_out_valid, a_out_ctrl, a_out_data); end
        checks++; if (b_out_valid !== 1'b0 || b_out_ctrl !== 8'h00 || b_out_data !== 96'hF00D)
            begin errors++; $display("FAIL bubble_b: got %b/%h/%h expected 0/00/F00D", b_out_valid, b_out_ctrl, b_out_data); end
        drain();
    endtask

    task automatic test_skid0();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 96'h61; in_ctrl = 8'h16;
        tick();
        in_data = 96'h62; in_ctrl = 8'h26;
        #3;
        checks++; if (b_in_ready !== 1'b0 || b_count !== 2'd1) begin errors++; $display("FAIL skid0_block: got rdy=%b count=%0d expected 0/1", b_in_ready, b_count); end
        out_ready = 1'b1;
        #1;
        checks++; if (b_in_ready !== 1'b1) begin errors++; $display("FAIL skid0_comb_ready: got %b expected 1", b_in_ready); end
        tick();
        in_valid = 1'b0;
        #3;
        checks++; if (b_out_valid !== 1'b1 || b_count !== 2'd1 || b_out_data !== 96'h62 || b_out_ctrl !== 8'h26)
            begin errors++; $display("FAIL skid0_passthru: got %b/%0d/%h/%h expected 1/1/62/26", b_out_valid, b_count, b_out_data, b_out_ctrl); end
        drain();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 96'h71; in_ctrl = 8'h71;
        tick();
        in_data = 96'h72;
        tick();
        #2;
        rst = 1'b0;
        #1;
        checks++; if (a_out_valid !== 1'b0 || a_count !== 2'd0 || a_out_ctrl !== 8'h00 || a_out_data !== 96'h0)
            begin errors++; $display("FAIL reset_mid_a: got %b/%0d/%h/%h expected 0/0/00/0", a_out_valid, a_count, a_out_ctrl, a_out_data); end
        checks++; if (b_out_valid !== 1'b0 || b_count !== 2'd0) begin errors++; $display("FAIL reset_mid_b: got %b/%0d expected 0/0", b_out_valid, b_count); end
        tick();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        tick();
        #3;
        checks++; if (a_out_valid !== 1'b0 || b_out_valid !== 1'b0) begin errors++; $display("FAIL reset_mid_pulse: got %b/%b expected 0/0", a_out_valid, b_out_valid); end
        drain();
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 39) == 0);
            in_data   = {$urandom, $urandom, $urandom};
            in_ctrl   = 8'($urandom);
            #3;
            checks++; if (a_in_ready !== ready_a()) begin errors++; $display("FAIL rnd_a_ready[%0d]: got %b expected %b", n, a_in_ready, ready_a()); end
            checks++; if (a_out_valid !== (qa.size() > 0)) begin errors++; $display("FAIL rnd_a_valid[%0d]: got %b expected %b", n, a_out_valid, qa.size() > 0); end
            checks++; if (a_out_data !== last_a) begin errors++; $display("FAIL rnd_a_data[%0d]: got %h expected %h", n, a_out_data, last_a); end
            checks++; if (a_out_ctrl !== ((qa.size() > 0) ? qa[0].c : 8'h00)) begin errors++; $display("FAIL rnd_a_ctrl[%0d]: got %h expected %h", n, a_out_ctrl, (qa.size() > 0) ? qa[0].c : 8'h00); end
            checks++; if (a_count !== 2'(qa.size())) begin errors++; $display("FAIL rnd_a_count[%0d]: got %0d expected %0d", n, a_count, qa.size()); end
            checks++; if (b_in_ready !== ready_b()) begin errors++; $display("FAIL rnd_b_ready[%0d]: got %b expected %b", n, b_in_ready, ready_b()); end
            checks++; if (b_out_valid !== (qb.size() > 0)) begin errors++; $display("FAIL rnd_b_valid[%0d]: got %b expected %b", n, b_out_valid, qb.size() > 0); end
            checks++; if (b_out_data !== last_b) begin errors++; $display("FAIL rnd_b_data[%0d]: got %h expected %h", n, b_out_data, last_b); end
            checks++; if (b_out_ctrl !== ((qb.size() > 0) ? qb[0].c : 8'h00)) begin errors++; $display("FAIL rnd_b_ctrl[%0d]: got %h expected %h", n, b_out_ctrl, (qb.size() > 0) ? qb[0].c : 8'h00); end
            checks++; if (b_count !== 2'(qb.size())) begin errors++; $display("FAIL rnd_b_count[%0d]: got %0d expected %0d", n, b_count, qb.size()); end
            tick();
        end
        drain();
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; in_ctrl = '0;
        test_reset();
        test_stream();
        test_stall();
        test_flush();
        test_bubble();
        test_skid0();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
